// File: rtl/claw_pkg.sv
// Shared claw machine types and constants: refund dispenser states, coin values,
// and the largest per-game refund the claw FSM can emit.
package claw_pkg;

  typedef enum logic [1:0] {
    RD_IDLE,
    RD_REQ,
    RD_GAP,
    RD_FAULT
  } refund_state_e;

  localparam int COIN_ONE    = 1;
  localparam int COIN_TWO    = 2;
  localparam int BALANCE_MAX = 12;

  // Dollar value of the coin type currently being dispensed.
  function automatic logic [1:0] coin_value(input logic two);
    return two ? 2'(COIN_TWO) : 2'(COIN_ONE);
  endfunction

endpackage

// File: rtl/refund_timer.sv
// Loadable up/down cycle counter with a terminal-count flag; the refund
// dispenser shares one instance between the ack timeout and the settle gap.
module refund_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         up,
  input  logic         down,
  input  logic [W-1:0] term_val,
  output logic         term
);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (up) begin
      count <= count + W'(1);
    end else if (down) begin
      count <= count - W'(1);
    end
  end

  assign term = (count == term_val);

endmodule

// File: rtl/refund_dispenser.sv
// Refund dispenser: accumulates refund dollars from the claw FSM and pays them
// out one coin per hopper req/ack handshake. Define REFUND_TWO_COIN_EN to pay
// with $2 coins greedily; otherwise every coin is $1.
module refund_dispenser
  import claw_pkg::*;
#(
  parameter int PEND_W      = 5,
  parameter int ACK_TIMEOUT = 64,
  parameter int GAP_CYCLES  = 4
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [3:0]        balance,
  input  logic              coin_ack,
  input  logic              clear_fault,
  output logic              coin_req,
  output logic              coin_two,
  output logic              busy,
  output logic [PEND_W-1:0] pending,
  output logic              fault,
  output logic              overflow
);

  localparam int TMAX = (ACK_TIMEOUT > GAP_CYCLES) ? ACK_TIMEOUT : GAP_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int SW   = PEND_W + 2;

  localparam logic signed [SW-1:0] PEND_MAX_S = {2'b00, {PEND_W{1'b1}}};

  refund_state_e     state;
  logic              ack_take;
  logic [1:0]        paid;
  logic signed [SW-1:0] acc_sum;
  logic              two_avail;

  logic              tmr_load;
  logic [TW-1:0]     tmr_val;
  logic              tmr_up;
  logic              tmr_down;
  logic [TW-1:0]     tmr_term_val;
  logic              tmr_hit;

  // Clamp the signed running sum into the accumulator range.
  function automatic logic [PEND_W-1:0] sat_pending(input logic signed [SW-1:0] s);
    if (s < 0) begin
      return '0;
    end else if (s > PEND_MAX_S) begin
      return PEND_MAX_S[PEND_W-1:0];
    end else begin
      return s[PEND_W-1:0];
    end
  endfunction

  function automatic logic sat_over(input logic signed [SW-1:0] s);
    return (s > PEND_MAX_S);
  endfunction

  // Only an ack seen while requesting actually pays out a coin.
  assign ack_take = (state == RD_REQ) && coin_ack;
  assign paid     = ack_take ? coin_value(coin_two) : 2'd0;

  assign acc_sum = $signed({2'b00, pending})
                 + $signed({{(SW-4){1'b0}}, balance})
                 - $signed({{(SW-2){1'b0}}, paid});

`ifdef REFUND_TWO_COIN_EN
  assign two_avail = (pending >= PEND_W'(COIN_TWO));
`else
  assign two_avail = 1'b0;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pending  <= '0;
      overflow <= 1'b0;
    end else begin
      pending <= sat_pending(acc_sum);
      if (sat_over(acc_sum)) begin
        overflow <= 1'b1;
      end else if (clear_fault) begin
        overflow <= 1'b0;
      end
    end
  end

  // Timer counts up toward the ack timeout in REQ and down through the settle gap.
  always_comb begin
    tmr_load     = 1'b0;
    tmr_val      = '0;
    tmr_up       = 1'b0;
    tmr_down     = 1'b0;
    tmr_term_val = TW'(1);
    case (state)
      RD_IDLE: begin
        tmr_load = (pending != '0);
      end
      RD_REQ: begin
        tmr_term_val = TW'(ACK_TIMEOUT - 1);
        if (coin_ack) begin
          tmr_load = 1'b1;
          tmr_val  = TW'(GAP_CYCLES);
        end else begin
          tmr_up = 1'b1;
        end
      end
      RD_GAP: begin
        if (tmr_hit) begin
          tmr_load = 1'b1;
        end else begin
          tmr_down = 1'b1;
        end
      end
      RD_FAULT: begin
        tmr_load = clear_fault;
      end
      default: begin
        tmr_load = 1'b1;
      end
    endcase
  end

  refund_timer #(
    .W (TW)
  ) u_timer (
    .clk      (clk),
    .rstn     (rstn),
    .load     (tmr_load),
    .load_val (tmr_val),
    .up       (tmr_up),
    .down     (tmr_down),
    .term_val (tmr_term_val),
    .term     (tmr_hit)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= RD_IDLE;
      coin_req <= 1'b0;
      coin_two <= 1'b0;
      fault    <= 1'b0;
    end else begin
      case (state)
        RD_IDLE: begin
          if (pending != '0) begin
            state    <= RD_REQ;
            coin_req <= 1'b1;
            coin_two <= two_avail;
          end
        end
        RD_REQ: begin
          // An ack on the final timeout cycle still counts as a dropped coin.
          if (coin_ack) begin
            state    <= RD_GAP;
            coin_req <= 1'b0;
          end else if (tmr_hit) begin
            state    <= RD_FAULT;
            coin_req <= 1'b0;
            fault    <= 1'b1;
          end
        end
        RD_GAP: begin
          if (tmr_hit) begin
            if (pending != '0) begin
              state    <= RD_REQ;
              coin_req <= 1'b1;
              coin_two <= two_avail;
            end else begin
              state <= RD_IDLE;
            end
          end
        end
        RD_FAULT: begin
          if (clear_fault) begin
            state <= RD_IDLE;
            fault <= 1'b0;
          end
        end
        default: begin
          state    <= RD_IDLE;
          coin_req <= 1'b0;
          fault    <= 1'b0;
        end
      endcase
    end
  end

  assign busy = (state != RD_IDLE) || (pending != '0);

endmodule
